// File: rtl/crc_arb_if.sv
// crc_arb_if: frame-source side and crc side of the crc arbiter.
// master = requesters/crc consumer, slave = the arbiter.
interface crc_arb_if #(parameter int NREQ = 4);
   localparam int IW = $clog2(NREQ);
   logic [NREQ-1:0]   req, req_sop, req_eop, gnt;
   logic [2*NREQ-1:0] req_d;
   logic [1:0]        crc_d;
   logic              crc_sop, crc_eop, err_timeout, err_proto;
   logic [IW-1:0]     owner;
   modport master (output req, req_d, req_sop, req_eop,
                   input gnt, crc_d, crc_sop, crc_eop, owner, err_timeout, err_proto);
   modport slave  (input req, req_d, req_sop, req_eop,
                   output gnt, crc_d, crc_sop, crc_eop, owner, err_timeout, err_proto);
endinterface

// File: rtl/crc_arb.sv
// crc_arb: round-robin arbiter feeding one serial crc appender, one frame at a time,
// holding off the next frame until the crc trailer has drained.
module crc_arb #(
   parameter int NREQ    = 4,
   parameter int GAP     = 16,
   parameter int TIMEOUT = 8
) (
   input logic      clk,
   input logic      rst_n,
   crc_arb_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(GAP + TIMEOUT);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FRAME, S_GAP} state_t;
   state_t          state, state_n;
   logic [IW-1:0]   w, w_n, rr, rr_n, pick, owner_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [NREQ-1:0] gnt_n;
   logic [1:0]      d_n, d_w;
   logic            sop_n, eop_n, et_n, ep_n, found, g, req_w, sop_w, eop_w;
   assign g     = bus.gnt[w];
   assign req_w = bus.req[w];
   assign sop_w = bus.req_sop[w];
   assign eop_w = bus.req_eop[w];
   assign d_w   = bus.req_d[{w, 1'b0} +: 2];
   // first requester after the rr pointer, wrapping
   always_comb begin
      pick  = rr;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++)
         if (!found && bus.req[IW'((int'(rr) + k) % NREQ)]) begin
            pick  = IW'((int'(rr) + k) % NREQ);
            found = 1'b1;
         end
   end
   always_comb begin
      state_n = state;
      w_n     = w;
      rr_n    = rr;
      cnt_n   = cnt;
      gnt_n   = bus.gnt;
      owner_n = bus.owner;
      d_n     = 2'b00;
      sop_n   = 1'b0;
      eop_n   = 1'b0;
      et_n    = 1'b0;
      ep_n    = 1'b0;
      case (state)
         S_IDLE: if (|bus.req) begin
            state_n    = S_WAIT;
            w_n        = pick;
            rr_n       = pick;
            cnt_n      = '0;
            gnt_n      = '0;
            gnt_n[pick] = 1'b1;
         end
         S_WAIT: if (g && sop_w) begin
            d_n     = d_w;
            sop_n   = 1'b1;
            eop_n   = eop_w;
            owner_n = w;
            cnt_n   = '0;
            state_n = eop_w ? S_GAP : S_FRAME;
            gnt_n   = eop_w ? '0 : bus.gnt;
         end else if (!req_w) begin
            gnt_n   = '0;
            state_n = S_IDLE;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            gnt_n   = '0;
            et_n    = 1'b1;
            state_n = S_IDLE;
         end else
            cnt_n = cnt + 1'b1;
         // a repeated sop mid-frame is flagged, its data still goes through
         S_FRAME: if (g) begin
            d_n   = d_w;
            eop_n = eop_w;
            ep_n  = sop_w;
            if (eop_w) begin
               state_n = S_GAP;
               gnt_n   = '0;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = cnt == CW'(GAP - 1) ? S_IDLE : S_GAP;
            cnt_n   = cnt + 1'b1;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state           <= S_IDLE;
         w               <= '0;
         rr              <= IW'(NREQ - 1);
         cnt             <= '0;
         bus.gnt         <= '0;
         bus.crc_d       <= '0;
         bus.crc_sop     <= 1'b0;
         bus.crc_eop     <= 1'b0;
         bus.owner       <= '0;
         bus.err_timeout <= 1'b0;
         bus.err_proto   <= 1'b0;
      end else begin
         state           <= state_n;
         w               <= w_n;
         rr              <= rr_n;
         cnt             <= cnt_n;
         bus.gnt         <= gnt_n;
         bus.crc_d       <= d_n;
         bus.crc_sop     <= sop_n;
         bus.crc_eop     <= eop_n;
         bus.owner       <= owner_n;
         bus.err_timeout <= et_n;
         bus.err_proto   <= ep_n;
      end
   ap_params: assert property (@(posedge clk)
      GAP >= 16 && TIMEOUT >= 2 && NREQ >= 2 && NREQ <= 8);
endmodule
